// File: rtl/perf_pkg.sv
// Shared types and default sizes for the performance counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_t;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_WIN_W  = 32;

endpackage

// File: rtl/perf_counter.sv
// One event counter with sticky overflow; wraps or saturates at all-ones.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf <= 1'b1;
        if (SATURATE == 0) count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Windowed event counter bank with a registered read port.
// Define PERF_SNAPSHOT_EN to capture counters at window end and read the snapshot.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int   NUM_CH   = DEF_NUM_CH,
  parameter int   CNT_W    = DEF_CNT_W,
  parameter int   WIN_W    = DEF_WIN_W,
  parameter int   SATURATE = 0,
  localparam int  IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              clear,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              busy,
  output logic              done
);

  perf_state_t      state;
  logic [WIN_W-1:0] remaining;
  logic             run_end;

  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;

  logic [CNT_W-1:0] src_cnt [NUM_CH];
  logic [NUM_CH-1:0] src_ovf;
  logic [CNT_W-1:0] sel_data;
  logic             sel_ovf;

  // Stop wins over expiry, so a stopped final cycle never produces done.
  assign run_end = (state == RUN) && !stop && (remaining == WIN_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (win_len != '0) begin
              state     <= RUN;
              remaining <= win_len;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          remaining <= remaining - 1'b1;
          if (stop) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
          end else if (run_end) begin
            state     <= DONE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (event_i[i] && (state == RUN)),
      .clr   (clear),
      .count (cnt[i]),
      .ovf   (ovf[i])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  logic             snap_take;
  logic [CNT_W-1:0] shadow_cnt [NUM_CH];
  logic [NUM_CH-1:0] shadow_ovf;

  // Copy one cycle after the last RUN edge so the final cycle's events are included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_take  <= 1'b0;
      shadow_ovf <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_cnt[i] <= '0;
    end else begin
      snap_take <= run_end;
      if (clear) begin
        shadow_ovf <= '0;
        for (int i = 0; i < NUM_CH; i++) shadow_cnt[i] <= '0;
      end else if (snap_take) begin
        shadow_ovf <= ovf;
        for (int i = 0; i < NUM_CH; i++) shadow_cnt[i] <= cnt[i];
      end
    end
  end

  assign src_cnt = shadow_cnt;
  assign src_ovf = shadow_ovf;
`else
  assign src_cnt = cnt;
  assign src_ovf = ovf;
`endif

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    if (int'(rd_idx) < NUM_CH) begin
      sel_data = src_cnt[rd_idx];
      sel_ovf  = src_ovf[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= sel_data;
        rd_ovf  <= sel_ovf;
      end
    end
  end

endmodule
